// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM state type and byte-enable bases for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-wide data memory req/ack bus; master = LSU, slave = memory
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane steering, load extension and request legality checks
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lanes,
  output logic [31:0] ldata,
  output logic        misaligned,
  output logic        illegal
);

  logic [15:0] lane;

  always_comb begin
    lane        = 16'(rdata >> {off, 3'b000});
    be          = 4'b0000;
    wdata_lanes = wdata;
    ldata       = 32'h0;

    // funct3[1:0] is the access size for both signed and unsigned variants
    case (funct3[1:0])
      2'b00: begin
        be          = BE_B << off;
        wdata_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        be          = BE_H << off;
        wdata_lanes = {2{wdata[15:0]}};
      end
      2'b10: be = BE_W;
      default: be = 4'b0000;
    endcase

    case (funct3)
      F3_B:    ldata = {{24{lane[7]}}, lane[7:0]};
      F3_H:    ldata = {{16{lane[15]}}, lane[15:0]};
      F3_W:    ldata = rdata;
      F3_BU:   ldata = {24'h0, lane[7:0]};
      F3_HU:   ldata = {16'h0, lane[15:0]};
      default: ldata = 32'h0;
    endcase

    illegal    = we ? (funct3 > F3_W) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00);
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V load/store stage over a req/ack memory bus; LSU_TIMEOUT_EN adds a REQ abort timer
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err,
  load_store_unit_if.master  mem
);

  lsu_state_t state;
  logic       cap_we;
  logic [2:0] cap_f3;
  logic [1:0] cap_off;

  logic        al_we;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ldata;
  logic        al_misaligned;
  logic        al_illegal;

  // In IDLE the aligner decodes the incoming request; afterwards it works on the captured one
  assign al_we  = (state == IDLE) ? req_we     : cap_we;
  assign al_f3  = (state == IDLE) ? req_funct3 : cap_f3;
  assign al_off = (state == IDLE) ? addr[1:0]  : cap_off;

  lsu_align u_align (
    .we          (al_we),
    .funct3      (al_f3),
    .off         (al_off),
    .wdata       (wdata),
    .rdata       (mem.mem_rdata),
    .be          (al_be),
    .wdata_lanes (al_wdata),
    .ldata       (al_ldata),
    .misaligned  (al_misaligned),
    .illegal     (al_illegal)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          timed_out;
  assign timed_out = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'h0;
      resp_err      <= 1'b0;
      cap_we        <= 1'b0;
      cap_f3        <= 3'b000;
      cap_off       <= 2'b00;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= 4'b0000;
      mem.mem_wdata <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_f3    <= req_funct3;
            cap_off   <= addr[1:0];
            req_ready <= 1'b0;
            if (al_illegal || al_misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state         <= REQ;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= req_we;
              mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem.mem_be    <= al_be;
              mem.mem_wdata <= al_wdata;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt       <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            state       <= RESP;
            mem.mem_req <= 1'b0;
            resp_valid  <= 1'b1;
            resp_err    <= 1'b0;
            resp_rdata  <= cap_we ? 32'h0 : al_ldata;
          end
`ifdef LSU_TIMEOUT_EN
          else if (timed_out) begin
            state       <= RESP;
            mem.mem_req <= 1'b0;
            resp_valid  <= 1'b1;
            resp_err    <= 1'b1;
            resp_rdata  <= 32'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_mis = 0;

  load_store_unit_if #(.ADDR_W(32)) mem ();

  load_store_unit #(
    .ADDR_W(32)
`ifdef LSU_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem        (mem.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Leaves the caller 1ns into the cycle after the accepting edge
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    check("ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Ack arrives one cycle after mem_req rises, so resp_valid lands three cycles after accept
  task automatic access(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    issue(we, f3, a, wd);
    @(negedge clk);
    check({tag, "_mem_req"},   32'(mem.mem_req), 32'd1);
    check({tag, "_mem_we"},    32'(mem.mem_we), 32'(we));
    check({tag, "_mem_addr"},  mem.mem_addr, exp_addr);
    check({tag, "_mem_be"},    32'(mem.mem_be), 32'(exp_be));
    if (we) check({tag, "_mem_wdata"}, mem.mem_wdata, exp_wd);
    check({tag, "_busy"},      32'(req_ready), 32'd0);
    check({tag, "_no_early"},  32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 mem.mem_ack = 1'b1; mem.mem_rdata = rd;
    @(posedge clk);
    #1 mem.mem_ack = 1'b0; mem.mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_resp_err"},   32'(resp_err), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, exp_rd);
    check({tag, "_req_dropped"}, 32'(mem.mem_req), 32'd0);
    @(negedge clk);
    check({tag, "_pulse_end"},  32'(resp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    check({tag, "_rdata_held"}, resp_rdata, exp_rd);
  endtask

  task automatic bad_req(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a);
    issue(we, f3, a, 32'hFFFF_FFFF);
    @(negedge clk);
    check({tag, "_no_mem_req"}, 32'(mem.mem_req), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_resp_err"},   32'(resp_err), 32'd1);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    @(negedge clk);
    check({tag, "_pulse_end"},  32'(resp_valid), 32'd0);
    check({tag, "_still_idle"}, 32'(mem.mem_req), 32'd0);
  endtask

  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err",   32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_req",    32'(mem.mem_req), 32'd0);
    check("rst_mem_be",     32'(mem.mem_be), 32'd0);
    check("rst_mem_addr",   mem.mem_addr, 32'h0);
    rst = 1'b0;

    access("lw",  1'b0, F3_W,  32'h100, 32'h0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    access("lb",  1'b0, F3_B,  32'h103, 32'h0, 32'h80112233, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    access("lbu", 1'b0, F3_BU, 32'h103, 32'h0, 32'h80112233, 32'h100, 4'b1000, 32'h0, 32'h00000080);
    access("lh",  1'b0, F3_H,  32'h102, 32'h0, 32'h80112233, 32'h100, 4'b1100, 32'h0, 32'hFFFF8011);
    access("lhu", 1'b0, F3_HU, 32'h102, 32'h0, 32'h80112233, 32'h100, 4'b1100, 32'h0, 32'h00008011);
    access("lb1", 1'b0, F3_B,  32'h101, 32'h0, 32'h80112233, 32'h100, 4'b0010, 32'h0, 32'h00000022);
    access("sh",  1'b1, F3_H,  32'h202, 32'h0000ABCD, 32'h12345678, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
    access("sb",  1'b1, F3_B,  32'h301, 32'h12345678, 32'h0, 32'h300, 4'b0010, 32'h78787878, 32'h0);
    access("sw",  1'b1, F3_W,  32'h404, 32'hCAFEF00D, 32'h0, 32'h404, 4'b1111, 32'hCAFEF00D, 32'h0);

    bad_req("lw_mis",   1'b0, F3_W,   32'h101);
    bad_req("sh_mis",   1'b1, F3_H,   32'h203);
    bad_req("st_f3_011", 1'b1, 3'b011, 32'h200);
    bad_req("ld_f3_110", 1'b0, 3'b110, 32'h200);

    // Reset while waiting for the memory, then a late ack that must be ignored
    issue(1'b0, F3_W, 32'h500, 32'h0);
    @(negedge clk);
    check("rstmid_in_req", 32'(mem.mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; mem.mem_ack = 1'b1; mem.mem_rdata = 32'h11111111;
    @(negedge clk);
    check("rstmid_req_drop",  32'(mem.mem_req), 32'd0);
    check("rstmid_ready",     32'(req_ready), 32'd1);
    check("rstmid_no_resp",   32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 mem.mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_no_resp", 32'(resp_valid), 32'd0);
    check("late_ack_no_req",  32'(mem.mem_req), 32'd0);
    check("late_ack_rdata",   resp_rdata, 32'h0);

    access("lw_after_rst", 1'b0, F3_W, 32'h600, 32'h0, 32'h0BADF00D, 32'h600, 4'b1111, 32'h0, 32'h0BADF00D);

`ifdef LSU_TIMEOUT_EN
    begin
      int req_cycles = 0;
      issue(1'b0, F3_W, 32'h700, 32'h0);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem.mem_req) req_cycles++;
        if (resp_valid) break;
      end
      check("tmo_req_cycles", 32'(req_cycles), 32'd4);
      check("tmo_resp_valid", 32'(resp_valid), 32'd1);
      check("tmo_resp_err",   32'(resp_err), 32'd1);
      check("tmo_resp_rdata", resp_rdata, 32'h0);
      @(negedge clk);
      check("tmo_ready_back", 32'(req_ready), 32'd1);
    end
    issue(1'b0, F3_W, 32'h704, 32'h0);
    repeat (3) @(posedge clk);
    #1 mem.mem_ack = 1'b1; mem.mem_rdata = 32'h13579BDF;
    @(posedge clk);
    #1 mem.mem_ack = 1'b0;
    @(negedge clk);
    check("tmo_ack_resp_valid", 32'(resp_valid), 32'd1);
    check("tmo_ack_resp_err",   32'(resp_err), 32'd0);
    check("tmo_ack_resp_rdata", resp_rdata, 32'h13579BDF);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Takes the ALU result as the effective address and performs RISC-V loads and stores: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Talks to a word-wide data memory over a req/ack handshake.
- Returns aligned, extended load data to writeback as a one-cycle response.

Parameters:
- ADDR_W, 32, address width; addr and mem_addr are this wide.
- TIMEOUT_CYCLES, 16, maximum REQ-state cycles before abort. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  access request from the execute stage.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 access size/sign code.
- addr  in  ADDR_W  effective address, i.e. the ALU out value.
- wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle pulse marking a completed access.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned address, illegal funct3, or timeout; qualified by resp_valid.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word address: {addr[ADDR_W-1:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-steered store data.
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.

Behaviour:
- Reset values: every registered output is 0 and req_ready is 1. State is IDLE.
- Reset mid-operation: the FSM returns to IDLE and mem_req drops on the next edge. A late mem_ack arriving in IDLE is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - req_ready=1.
  - On accept, capture req_we, funct3, addr and wdata.
  - Decode and check the request:
    - illegal funct3: loads 011/110/111; stores any funct3 above 010.
    - misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - If either check fails, go to RESP with resp_err=1; no memory cycle is issued.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1.
  - mem_we, mem_addr, mem_be and mem_wdata are held stable for the whole state.
  - On mem_ack: register the extended load result (0 for stores) and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready is 0 in this cycle, so back-to-back requests are spaced by at least one idle-accept cycle.
- mem_ack outside REQ is ignored.
- Latency:
  - Accept in cycle 0; mem_req rises in cycle 1; ack in cycle k≥1; resp_valid in cycle k+1.
  - Error path: resp_valid in cycle 1.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << addr[1:0].
  - word: 4'b1111.
- Store data: the byte/half is replicated across all lanes (wdata[7:0]×4 or wdata[15:0]×2); mem_be selects which lanes are written.
- Load data: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- resp_rdata holds its value until the next response.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES, mem_req drops, the FSM goes to RESP with resp_err=1, and resp_rdata=0.
  - mem_ack in the same cycle as the timeout wins; the access completes normally.
- Undefined: no counter; the FSM waits in REQ indefinitely.

Decomposition:
- Package lsu_pkg:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - lsu_state_t enum: IDLE, REQ, RESP.
  - Byte-enable base constants.
- Sub-module lsu_align: purely combinational; computes mem_be, mem_wdata, the extended load data and the misaligned/illegal flags from funct3, addr[1:0], wdata and mem_rdata.
- load_store_unit: holds the FSM, capture registers and optional timeout counter.

Test Plan:
- LW at addr=0x100 with mem_rdata=0xDEADBEEF and ack one cycle after mem_req → mem_addr=0x100, mem_be=1111, resp_valid 3 cycles after accept, resp_rdata=0xDEADBEEF, resp_err=0.
- LB at addr=0x103 with mem_rdata=0x80112233 → mem_be=1000, resp_rdata=0xFFFFFF80. The same access with LBU → resp_rdata=0x00000080.
- SH at addr=0x202 with wdata=0x0000ABCD → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, resp_rdata=0.
- LW at addr=0x101 → no mem_req, resp_valid+resp_err one cycle after accept. Store with funct3=011 → same response.
- rst asserted while in REQ, then a late mem_ack → mem_req=0 the next cycle, ack ignored, no resp_valid.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ack never asserted → mem_req drops after 4 cycles and resp_err=1. A separate run with the ack on the timeout cycle → normal completion.
